// File: rtl/feature_map_ram_acc.sv
// Feature-map row buffer: PARA_Y float16 lanes x DEPTH rows, overwrite or
// accumulate writes through pipelined per-lane adders, plus clear-all sweep.
//
// floating_point_add ports:
//   clk    : clock (only used when LATENCY > 0)
//   a, b   : float16 operands
//   result : a + b, round-to-nearest-even, LATENCY cycles after a/b
//
// feature_map_ram_acc ports:
//   clk, rst             : clock, synchronous active-high reset
//   wr_valid / wr_ready  : write handshake (wr_ready is combinational)
//   wr_mode              : 0 overwrite, 1 accumulate, 2 clear-all, 3 no-op
//   wr_addr, wr_din      : target row and packed lane data
//   rd_en, rd_addr       : registered read request
//   rd_dout, rd_dout_valid : read data and its one-cycle valid
//   busy                 : accumulation in flight or clear sweep active

module floating_point_add #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);

    function automatic logic [15:0] fp16_add(input logic [15:0] p,
                                             input logic [15:0] q);
        logic [15:0] x, y;
        logic [4:0]  ex, ey, d;
        logic [13:0] mx, my;
        logic [14:0] s;
        logic [5:0]  e;
        logic [11:0] m;
        logic        st, rup;
        // x always holds the larger magnitude
        if (p[14:0] >= q[14:0]) begin
            x = p;
            y = q;
        end else begin
            x = q;
            y = p;
        end
        if (x[14:10] == 5'h1F) begin
            if (x[9:0] != 10'd0) return 16'h7E00;
            if (y[14:10] == 5'h1F && y[15] != x[15]) return 16'h7E00;
            return x;
        end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        // hidden bit, fraction, guard/round/sticky
        mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
        d  = ex - ey;
        st = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (5'(i) < d) begin
                st = st | my[0];
                my = my >> 1;
            end
        end
        my[0] = my[0] | st;
        if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        // exact cancellation gives +0; -0 only from two negative zeros
        if (s == 15'd0) return {x[15] & y[15], 15'd0};
        e = {1'b0, ex};
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 6'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13] && e > 6'd1) begin
                    s = s << 1;
                    e = e - 6'd1;
                end
            end
        end
        m   = {1'b0, s[13:3]};
        rup = s[2] & (s[1] | s[0] | s[3]);
        m   = m + {11'd0, rup};
        if (m[11]) begin
            m = m >> 1;
            e = e + 6'd1;
        end
        if (e >= 6'd31) return {x[15], 5'h1F, 10'd0};
        // no hidden bit left means the result stayed subnormal
        return {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
    endfunction

    logic [15:0] sum;
    assign sum = fp16_add(a, b);

    generate
        if (LATENCY == 0) begin : g_comb
            assign result = sum;
        end else begin : g_pipe
            logic [15:0] stage [LATENCY];
            always_ff @(posedge clk) begin
                stage[0] <= sum;
                for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
            end
            assign result = stage[LATENCY-1];
        end
    endgenerate

endmodule

module feature_map_ram_acc #(
    parameter int DATA_WIDTH  = 16,
    parameter int PARA_Y      = 2,
    parameter int DEPTH       = 11,
    parameter int ADDR_WIDTH  = $clog2(DEPTH),
    parameter int ADD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [1:0]                   wr_mode,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic [PARA_Y*DATA_WIDTH-1:0] wr_din,
    input  logic                         rd_en,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [PARA_Y*DATA_WIDTH-1:0] rd_dout,
    output logic                         rd_dout_valid,
    output logic                         busy
);

    localparam int W = PARA_Y * DATA_WIDTH;
    localparam int L = ADD_LATENCY;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [1:0] M_OVR = 2'd0;
    localparam logic [1:0] M_ACC = 2'd1;
    localparam logic [1:0] M_CLR = 2'd2;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(DEPTH - 1);

    logic [W-1:0] mem [DEPTH];

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clr_row;

    // in-flight tracker: stage 0 loads at accept, stage L drives write-back
    logic [L:0]                 trk_v;
    logic [L:0][ADDR_WIDTH-1:0] trk_a;

    logic [W-1:0] op_a, op_b, sum_row;
    logic         in_flight, hazard, accept, acc_go;
    logic         wr_in_range, rd_in_range;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i <= L; i++) begin
            if (trk_v[i] && trk_a[i] == wr_addr) hazard = 1'b1;
        end
    end

    assign in_flight = |trk_v;
    assign busy      = in_flight || (state == S_CLEAR);
    assign wr_ready  = (state == S_IDLE) && !hazard &&
                       !(wr_mode == M_CLR && in_flight);
    assign accept    = wr_valid && wr_ready && !rst;
    assign acc_go    = accept && (wr_mode == M_ACC) && wr_in_range;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            clr_row <= '0;
            trk_v   <= '0;
            trk_a   <= '0;
        end else begin
            trk_v[0] <= acc_go;
            trk_a[0] <= wr_addr;
            for (int i = 1; i <= L; i++) begin
                trk_v[i] <= trk_v[i-1];
                trk_a[i] <= trk_a[i-1];
            end
            case (state)
                S_IDLE: begin
                    if (accept && wr_mode == M_CLR) begin
                        state   <= S_CLEAR;
                        clr_row <= '0;
                    end
                end
                S_CLEAR: begin
                    if (clr_row == LAST_ROW) state <= S_IDLE;
                    else clr_row <= clr_row + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // adder operand registers: current row and incoming partial sums
    always_ff @(posedge clk) begin
        if (acc_go) begin
            op_a <= mem[wr_addr];
            op_b <= wr_din;
        end
    end

    genvar g;
    generate
        for (g = 0; g < PARA_Y; g++) begin : g_lane
            floating_point_add #(
                .LATENCY(L)
            ) u_add (
                .clk    (clk),
                .a      (op_a[g*DATA_WIDTH +: DATA_WIDTH]),
                .b      (op_b[g*DATA_WIDTH +: DATA_WIDTH]),
                .result (sum_row[g*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    // hazard stall guarantees these never target the same row together
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept && wr_mode == M_OVR && wr_in_range)
                mem[wr_addr] <= wr_din;
            if (trk_v[L])
                mem[trk_a[L]] <= sum_row;
            if (state == S_CLEAR)
                mem[clr_row] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_dout       <= '0;
            rd_dout_valid <= 1'b0;
        end else begin
            rd_dout_valid <= rd_en;
            if (rd_en) rd_dout <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_feature_map_ram_acc.sv
// Scoreboard bench for feature_map_ram_acc: real-valued row model,
// expected reads queued at issue and checked by a separate monitor.

module tb_feature_map_ram_acc;

    localparam int DW    = 16;
    localparam int PY    = 2;
    localparam int DEPTH = 11;
    localparam int AW    = $clog2(DEPTH);
    localparam int L     = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wr_valid = 1'b0;
    logic            wr_ready;
    logic [1:0]      wr_mode = 2'd0;
    logic [AW-1:0]   wr_addr = '0;
    logic [PY*DW-1:0] wr_din = '0;
    logic            rd_en = 1'b0;
    logic [AW-1:0]   rd_addr = '0;
    logic [PY*DW-1:0] rd_dout;
    logic            rd_dout_valid;
    logic            busy;

    feature_map_ram_acc #(
        .DATA_WIDTH  (DW),
        .PARA_Y      (PY),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (AW),
        .ADD_LATENCY (L)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_mode       (wr_mode),
        .wr_addr       (wr_addr),
        .wr_din        (wr_din),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_dout       (rd_dout),
        .rd_dout_valid (rd_dout_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: rows as real numbers, pending accumulates by due edge
    real mv [DEPTH][PY];
    int  p_addr [$];
    int  p_due  [$];
    real p_s0   [$];
    real p_s1   [$];
    int  clr_t = -1000;

    logic [31:0] expq [$];
    logic [31:0] last_rd = '0;
    bit          mon_on = 0;
    int          nvec = 0;
    int          nbad = 0;

    function automatic logic [15:0] to_half(input real r);
        logic s;
        real  m;
        int   e;
        if (r == 0.0) return 16'h0000;
        s = (r < 0.0);
        m = s ? -r : r;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        return {s, 5'(e + 15), 10'($rtoi((m - 1.0) * 1024.0))};
    endfunction

    function automatic logic [31:0] pack(input real l0, input real l1);
        return {to_half(l1), to_half(l0)};
    endfunction

    function automatic real rq();
        return real'($urandom_range(0, 128)) / 4.0 - 16.0;
    endfunction

    function automatic real absr(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic bit m_in_flight(input int e);
        foreach (p_due[i]) if (p_due[i] >= e) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_clearing(input int e);
        return (e > clr_t) && (e <= clr_t + DEPTH);
    endfunction

    function automatic bit m_ready(input logic [1:0] md, input int ad,
                                   input int e);
        if (m_clearing(e)) return 1'b0;
        foreach (p_due[i])
            if (p_due[i] >= e && p_addr[i] == ad) return 1'b0;
        if (md == 2'd2 && m_in_flight(e)) return 1'b0;
        return 1'b1;
    endfunction

    // one clock: drive, check handshake/busy, queue read, advance model
    task automatic step(input bit r, input bit v, input logic [1:0] md,
                        input int ad, input real a0, input real a1,
                        input bit re, input int ra, output bit ok);
        int e;
        bit rdy, fl, cl;
        @(negedge clk);
        rst      = r;
        wr_valid = v;
        wr_mode  = md;
        wr_addr  = AW'(ad);
        wr_din   = pack(a0, a1);
        rd_en    = re;
        rd_addr  = AW'(ra);
        #1;
        e   = cyc + 1;
        fl  = m_in_flight(e);
        cl  = m_clearing(e);
        rdy = m_ready(md, ad, e);
        ok  = 1'b0;
        if (r) begin
            p_addr.delete();
            p_due.delete();
            p_s0.delete();
            p_s1.delete();
            clr_t   = -1000;
            last_rd = '0;
        end else begin
            chk("wr_ready", {31'd0, wr_ready}, {31'd0, rdy});
            chk("busy", {31'd0, busy}, {31'd0, fl || cl});
            if (re)
                expq.push_back(ra < DEPTH ?
                               pack(mv[ra][0], mv[ra][1]) : 32'd0);
            for (int i = p_due.size() - 1; i >= 0; i--) begin
                if (p_due[i] == e) begin
                    mv[p_addr[i]][0] = p_s0[i];
                    mv[p_addr[i]][1] = p_s1[i];
                    p_addr.delete(i);
                    p_due.delete(i);
                    p_s0.delete(i);
                    p_s1.delete(i);
                end
            end
            if (cl) begin
                mv[e - clr_t - 1][0] = 0.0;
                mv[e - clr_t - 1][1] = 0.0;
            end
            if (v && rdy) begin
                ok = 1'b1;
                case (md)
                    2'd0: if (ad < DEPTH) begin
                        mv[ad][0] = a0;
                        mv[ad][1] = a1;
                    end
                    2'd1: if (ad < DEPTH) begin
                        p_addr.push_back(ad);
                        p_due.push_back(e + L + 1);
                        p_s0.push_back(mv[ad][0] + a0);
                        p_s1.push_back(mv[ad][1] + a1);
                    end
                    2'd2: clr_t = e;
                    default: ;
                endcase
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        bit ok;
        for (int i = 0; i < n; i++) step(0, 0, 2'd0, 0, 0.0, 0.0, 0, 0, ok);
    endtask

    task automatic rd(input int ra);
        bit ok;
        step(0, 0, 2'd0, 0, 0.0, 0.0, 1, ra, ok);
    endtask

    // monitor: every presented read pops one expectation; held otherwise
    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_dout_valid) begin
                if (expq.size() == 0) begin
                    nvec++;
                    nbad++;
                    $display("FAIL rd_unexpected: got valid %h expected none",
                             rd_dout);
                end else begin
                    last_rd = expq.pop_front();
                    chk("rd_dout", rd_dout, last_rd);
                end
            end else begin
                if (expq.size() != 0) begin
                    nvec++;
                    nbad++;
                    $display("FAIL rd_missing: got no valid expected %h",
                             expq.pop_front());
                end
                chk("rd_hold", rd_dout, last_rd);
            end
        end
    end

    initial begin
        bit ok;
        int stalls;
        int md_r, ad;
        logic [1:0] md;
        foreach (mv[i, j]) mv[i][j] = 0.0;

        for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 0, 0.0, 0.0, 0, 0, ok);
        #2;
        chk("rst_rd_dout", rd_dout, 32'd0);
        chk("rst_rd_valid", {31'd0, rd_dout_valid}, 32'd0);
        mon_on = 1;

        // start from a known-zero array
        step(0, 1, 2'd2, 0, 0.0, 0.0, 0, 0, ok);
        idle(DEPTH + 1);

        // overwrite row 3 and read it back
        step(0, 1, 2'd0, 3, 1.0, 2.0, 0, 0, ok);
        rd(3);
        idle(2);

        // back-to-back accumulates to the same row stall L+1 cycles
        step(0, 1, 2'd0, 5, 0.5, 1.0, 0, 0, ok);
        step(0, 1, 2'd1, 5, 1.0, 1.0, 0, 0, ok);
        stalls = 0;
        ok = 0;
        while (!ok && stalls < 20) begin
            step(0, 1, 2'd1, 5, 1.0, 1.0, 0, 0, ok);
            if (!ok) stalls++;
        end
        chk("acc_stall", stalls, L + 1);
        idle(L + 2);
        rd(5);
        idle(2);

        // accumulate every row on consecutive cycles
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 2'd1, i, rq(), rq(), 0, 0, ok);
        idle(L + 2);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(2);

        // read during an in-flight accumulate sees the old row
        step(0, 1, 2'd1, 4, 2.5, -1.25, 0, 0, ok);
        rd(4);
        idle(L + 1);
        rd(4);
        idle(2);

        // fill then clear, reading through the sweep
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 2'd0, i, rq(), rq(), 0, 0, ok);
        step(0, 1, 2'd2, 0, 0.0, 0.0, 0, 0, ok);
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 1, 2'd0, 7, 1.0, 1.0, 1, i % DEPTH, ok);
        for (int i = 0; i < DEPTH; i++) rd(i);

        // clear-all waits for in-flight accumulation
        step(0, 1, 2'd1, 1, 3.0, 4.0, 0, 0, ok);
        stalls = 0;
        ok = 0;
        while (!ok && stalls < 20) begin
            step(0, 1, 2'd2, 0, 0.0, 0.0, 0, 0, ok);
            if (!ok) stalls++;
        end
        chk("clr_stall", stalls, L + 1);
        idle(DEPTH + 1);
        rd(1);

        // reset abandons a pending accumulate to row 2
        step(0, 1, 2'd0, 2, 0.75, -2.0, 0, 0, ok);
        step(0, 1, 2'd1, 2, 1.0, 1.0, 0, 0, ok);
        step(1, 0, 2'd0, 0, 0.0, 0.0, 0, 0, ok);
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("rst_valid", {31'd0, rd_dout_valid}, 32'd0);
        idle(L + 2);
        rd(2);
        idle(2);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            real a0, a1;
            md_r = $urandom_range(0, 99);
            md = (md_r < 30) ? 2'd0 : (md_r < 92) ? 2'd1 :
                 (md_r < 94) ? 2'd2 : 2'd3;
            ad = $urandom_range(0, 12);
            a0 = rq();
            a1 = rq();
            // keep sums inside the exactly representable range
            if (md == 2'd1 && ad < DEPTH &&
                (absr(mv[ad][0]) > 200.0 || absr(mv[ad][1]) > 200.0))
                md = 2'd0;
            step(0, $urandom_range(0, 3) != 0, md, ad, a0, a1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 12), ok);
        end

        idle(DEPTH + L + 3);
        for (int i = 0; i < DEPTH; i++) rd(i);
        idle(3);
        chk("drain", expq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
